// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit producing the HI/LO registers.
// One bit per RUN cycle: shift-add multiply or restoring divide on magnitudes, sign fix in FIX.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int ITER  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               load, mt_en;
    logic               is_div, sign_q, sign_r;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc, acc_step, fix_prod;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   rem_trial, fix_hi, fix_lo;
    logic               rem_ge;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WIDTH-1:0] mag_w(input logic [WIDTH-1:0] x, input logic is_signed);
        return (is_signed && x[WIDTH-1]) ? neg_w(x) : x;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(ITER - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        load  = (state == IDLE) && start;
        mt_en = (state == IDLE) && !start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            cnt  <= '0;
        end else begin
            done <= (state == FIX);
            if (load)              cnt <= '0;
            else if (state == RUN) cnt <= cnt + 1'b1;
        end
    end

    // acc holds {product_hi, multiplier/product_lo} for multiply, {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        rem_ge    = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
        rem_trial = acc[2*WIDTH-2:WIDTH-1] - opnd;
        if (is_div)
            acc_step = rem_ge ? {rem_trial, acc[WIDTH-2:0], 1'b1} : {acc[2*WIDTH-2:0], 1'b0};
        else
            acc_step = {mul_sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (load) begin
            is_div <= op[1];
            sign_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= op[0] & a[WIDTH-1];
            if (op[1]) begin
                acc  <= {{WIDTH{1'b0}}, mag_w(a, op[0])};
                opnd <= mag_w(b, op[0]);
            end else begin
                acc  <= {{WIDTH{1'b0}}, mag_w(b, op[0])};
                opnd <= mag_w(a, op[0]);
            end
        end else if (state == RUN) begin
            acc <= acc_step;
        end
    end

    always_comb begin
        fix_prod = sign_q ? neg_2w(acc) : acc;
        if (is_div) begin
            fix_lo = sign_q ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
            fix_hi = sign_r ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
        end else begin
            fix_lo = fix_prod[WIDTH-1:0];
            fix_hi = fix_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else if (mt_en) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit directly downstream of the immediate-extend / ALU-B operand mux.
- Consumes rs (operand a) and the selected B operand (operand b). Produces the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Multi-cycle; control stalls the pipeline on busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- ITER, 32, iteration cycles per operation; must equal WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request an operation; sampled only in IDLE
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  input  32  multiplicand / dividend (rs)
- b  input  32  multiplier / divisor (ALU B operand)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  32  MTHI/MTLO data
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; HI/LO hold the new result
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (synchronous, takes precedence over everything, including mid-operation):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Any in-flight operation is discarded.
- States: IDLE -> RUN -> FIX -> IDLE. There is no separate DONE state; done is registered.
- IDLE:
  - start=1: latch operands and op, go to RUN with counter=0. busy=1 from the next cycle.
  - Signed ops (op[0]=1): latch |a| and |b| and record sign_q = a[31]^b[31] and sign_r = a[31]. Unsigned ops: sign_q = sign_r = 0.
- RUN: exactly ITER cycles, one bit per cycle.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division, a 33-bit trial subtract per cycle.
  - The counter increments each cycle. When counter==ITER-1, go to FIX.
- FIX: one cycle.
  - Multiply: if sign_q, {hi,lo} = two's-complement negation of the 64-bit product.
  - Divide: lo = quotient, negated if sign_q; hi = remainder, negated if sign_r.
  - hi/lo are written at the end of FIX. Go to IDLE.
- Outputs and latency:
  - done=1 for exactly the first cycle back in IDLE.
  - busy=1 from the cycle after start through the FIX cycle inclusive: ITER+1 cycles.
  - Start edge to done cycle is ITER+2 = 34 cycles.
- hi/lo are not modified during RUN; they hold their previous values until the FIX edge.
- start while busy=1 is ignored, not queued.
- hi_we / lo_we:
  - Honoured only in IDLE when start=0; the write is visible the next cycle.
  - When hi_we and lo_we are both set, both registers get wdata.
  - Ignored when busy=1, or when start=1 in the same cycle (start wins).
  - Permitted in the done cycle.
- Divide by zero (b==0):
  - The operation still takes the full 34 cycles.
  - DIVU result: lo=32'hFFFF_FFFF, hi=a.
  - DIV result: computed on magnitudes with the normal sign fix. The quotient magnitude is all-ones, so lo = 32'hFFFF_FFFF, or 32'h0000_0001 if sign_q; hi = a.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. No trap.
- Width rules:
  - Magnitudes are treated as 32-bit unsigned, so |-2^31| = 0x8000_0000 is exact.
  - Negation is ~x+1 truncated to the field width (64 bits for the product, 32 bits for quotient/remainder).

Test Plan:
- Reset, then MULT a=0xFFFF_FFFD (-3), b=7 -> busy high for 33 cycles; done at cycle 34; hi=0xFFFF_FFFF, lo=0xFFFF_FFEB.
- MULTU a=b=0xFFFF_FFFF -> hi=0xFFFF_FFFE, lo=0x0000_0001. DIVU a=100, b=7 -> lo=0x0000_000E, hi=0x0000_0002.
- DIV a=0xFFFF_FFF9 (-7), b=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIV a=0x8000_0000, b=0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
- DIVU a=0x1234, b=0 -> done at cycle 34; lo=0xFFFF_FFFF, hi=0x0000_1234.
- hi_we=1, wdata=0xAAAA_5555 in IDLE -> hi=0xAAAA_5555 next cycle.
  - Same write plus a second start asserted at cycle 10 of a running op -> both ignored; the result matches the first op only.
  - hi_we asserted together with start -> the write is dropped.
- Start MULT, assert rst at RUN cycle 15 -> next cycle busy=0, done=0, hi=lo=0.
  - A new start after that completes normally with done at cycle 34.
